// File: rtl/fpgaram_pkg.sv
// rtl/fpgaram_pkg.sv - shared types and constants for the FPGA RAM boot controller
package fpgaram_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_LATCH,
    ST_SETUP,
    ST_WRITE,
    ST_HOLD
  } boot_state_t;

  localparam int WAIT_CNT_W = 4;

  localparam logic STROBE_OFF = 1'b1;
  localparam logic STROBE_ON  = 1'b0;

endpackage

// File: rtl/control_fpgaram_boot_write_seq.sv
// rtl/control_fpgaram_boot_write_seq.sv - SETUP/WRITE/HOLD strobe sequencer for one memory write
module fpgaram_write_seq
  import fpgaram_pkg::*;
#(
  parameter int BE_W        = 2,
  parameter int WAIT_CYCLES = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  output logic            done,
  output logic            cs,
  output logic            we,
  output logic            oe,
  output logic            adv,
  output logic [BE_W-1:0] lb_ub
);

  localparam logic [WAIT_CNT_W-1:0] CNT_LAST = WAIT_CNT_W'(WAIT_CYCLES - 1);

  boot_state_t           state_q, state_d;
  logic [WAIT_CNT_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Strobes decode straight from the state register; done marks the HOLD cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done    = 1'b0;
    cs      = STROBE_OFF;
    we      = STROBE_OFF;
    oe      = STROBE_OFF;
    adv     = STROBE_OFF;
    lb_ub   = '1;
    case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_SETUP;
      end
      ST_SETUP: begin
        cs      = STROBE_ON;
        adv     = STROBE_ON;
        lb_ub   = '0;
        cnt_d   = '0;
        state_d = ST_WRITE;
      end
      ST_WRITE: begin
        cs    = STROBE_ON;
        we    = STROBE_ON;
        lb_ub = '0;
        if (cnt_q == CNT_LAST) state_d = ST_HOLD;
        else                   cnt_d   = cnt_q + WAIT_CNT_W'(1);
      end
      ST_HOLD: begin
        lb_ub   = '0;
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: rtl/control_fpgaram_boot.sv
// rtl/control_fpgaram_boot.sv - SRAM front-end: micro pass-through or FIFO-to-memory boot engine
module control_fpgaram_boot
  import fpgaram_pkg::*;
#(
  parameter int                ADDR_W      = 22,
  parameter int                DATA_W      = 32,
  parameter int                BE_W        = DATA_W / 16,
  parameter int                WAIT_CYCLES = 2,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = '0
) (
  input  logic              control_mem_clk_i,
  input  logic              control_mem_rst_i,
  input  logic              micro_control_i,
  input  logic [ADDR_W-1:0] micro_sram_address_i,
  input  logic [DATA_W-1:0] micro_sram_datain_i,
  input  logic [BE_W-1:0]   micro_sram_lb_ub_i,
  input  logic              micro_sram_cs_i,
  input  logic              micro_sram_we_i,
  input  logic              micro_sram_oe_i,
  input  logic              micro_sram_adv_i,
  input  logic              boot_start_i,
  input  logic [ADDR_W-1:0] boot_len_i,
  input  logic              fifo_empty_i,
  input  logic [DATA_W-1:0] fifo_datain_i,
  output logic              read_fifo_o,
  output logic [ADDR_W-1:0] sram_address_o,
  output logic [DATA_W-1:0] sram_datain_o,
  output logic [BE_W-1:0]   sram_lb_ub_o,
  output logic              sram_cs_o,
  output logic              sram_we_o,
  output logic              sram_oe_o,
  output logic              sram_adv_o,
  output logic              sram_wait_o,
  output logic              boot_done_o,
  output logic              boot_ovf_o
);

  boot_state_t       state_q, state_d;
  logic [ADDR_W-1:0] addr_q, rem_q;
  logic [DATA_W-1:0] data_q;
  logic              done_q, ovf_q;
  logic              load, zero_len, latch, step, fin_done, fin_ovf, seq_start;

  logic              mic_sel_q;
  logic [ADDR_W-1:0] mic_addr_q;
  logic [DATA_W-1:0] mic_data_q;
  logic [BE_W-1:0]   mic_lb_ub_q;
  logic              mic_cs_q, mic_we_q, mic_oe_q, mic_adv_q;

  logic              seq_done, seq_cs, seq_we, seq_oe, seq_adv;
  logic [BE_W-1:0]   seq_lb_ub;

  fpgaram_write_seq #(
    .BE_W        (BE_W),
    .WAIT_CYCLES (WAIT_CYCLES)
  ) u_write_seq (
    .clk   (control_mem_clk_i),
    .rst_n (control_mem_rst_i),
    .start (seq_start),
    .done  (seq_done),
    .cs    (seq_cs),
    .we    (seq_we),
    .oe    (seq_oe),
    .adv   (seq_adv),
    .lb_ub (seq_lb_ub)
  );

  always_ff @(posedge control_mem_clk_i or negedge control_mem_rst_i) begin
    if (!control_mem_rst_i) state_q <= ST_IDLE;
    else                    state_q <= state_d;
  end

  // ST_WRITE here means the sequencer is running its SETUP/WRITE/HOLD phases.
  always_comb begin
    state_d     = state_q;
    read_fifo_o = 1'b0;
    seq_start   = 1'b0;
    load        = 1'b0;
    zero_len    = 1'b0;
    latch       = 1'b0;
    step        = 1'b0;
    fin_done    = 1'b0;
    fin_ovf     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (boot_start_i && !micro_control_i) begin
          if (boot_len_i != '0) begin
            load    = 1'b1;
            state_d = ST_FETCH;
          end else begin
            zero_len = 1'b1;
          end
        end
      end
      ST_FETCH: begin
        if (micro_control_i) begin
          state_d = ST_IDLE;
        end else if (!fifo_empty_i) begin
          read_fifo_o = 1'b1;
          state_d     = ST_LATCH;
        end
      end
      ST_LATCH: begin
        latch     = 1'b1;
        seq_start = 1'b1;
        state_d   = ST_WRITE;
      end
      ST_WRITE: begin
        if (seq_done) begin
          step = 1'b1;
          if (rem_q == ADDR_W'(1)) begin
            fin_done = 1'b1;
            state_d  = ST_IDLE;
          end else if (&addr_q) begin
            fin_done = 1'b1;
            fin_ovf  = 1'b1;
            state_d  = ST_IDLE;
          end else if (micro_control_i) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_FETCH;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge control_mem_clk_i or negedge control_mem_rst_i) begin
    if (!control_mem_rst_i) begin
      addr_q <= '0;
      rem_q  <= '0;
      data_q <= '0;
      done_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      if (load) begin
        addr_q <= BASE_ADDR;
        rem_q  <= boot_len_i;
        done_q <= 1'b0;
        ovf_q  <= 1'b0;
      end
      if (zero_len) begin
        done_q <= 1'b1;
        ovf_q  <= 1'b0;
      end
      if (latch) data_q <= fifo_datain_i;
      if (step) begin
        addr_q <= addr_q + ADDR_W'(1);
        rem_q  <= rem_q - ADDR_W'(1);
      end
      if (fin_done) done_q <= 1'b1;
      if (fin_ovf)  ovf_q  <= 1'b1;
    end
  end

  always_ff @(posedge control_mem_clk_i or negedge control_mem_rst_i) begin
    if (!control_mem_rst_i) begin
      mic_sel_q   <= 1'b0;
      mic_addr_q  <= '0;
      mic_data_q  <= '0;
      mic_lb_ub_q <= '1;
      mic_cs_q    <= STROBE_OFF;
      mic_we_q    <= STROBE_OFF;
      mic_oe_q    <= STROBE_OFF;
      mic_adv_q   <= STROBE_OFF;
    end else begin
      mic_sel_q   <= micro_control_i;
      mic_addr_q  <= micro_sram_address_i;
      mic_data_q  <= micro_sram_datain_i;
      mic_lb_ub_q <= micro_sram_lb_ub_i;
      mic_cs_q    <= micro_sram_cs_i;
      mic_we_q    <= micro_sram_we_i;
      mic_oe_q    <= micro_sram_oe_i;
      mic_adv_q   <= micro_sram_adv_i;
    end
  end

  // An active load keeps the bus even if the micro asks for it mid-word.
  always_comb begin
    if (state_q != ST_IDLE || !mic_sel_q) begin
      sram_address_o = addr_q;
      sram_datain_o  = data_q;
      sram_lb_ub_o   = seq_lb_ub;
      sram_cs_o      = seq_cs;
      sram_we_o      = seq_we;
      sram_oe_o      = seq_oe;
      sram_adv_o     = seq_adv;
    end else begin
      sram_address_o = mic_addr_q;
      sram_datain_o  = mic_data_q;
      sram_lb_ub_o   = mic_lb_ub_q;
      sram_cs_o      = mic_cs_q;
      sram_we_o      = mic_we_q;
      sram_oe_o      = mic_oe_q;
      sram_adv_o     = mic_adv_q;
    end
  end

  assign sram_wait_o = (state_q != ST_IDLE);
  assign boot_done_o = done_q;
  assign boot_ovf_o  = ovf_q;

endmodule

// File: tb/tb_control_fpgaram_boot.sv
// tb/tb_control_fpgaram_boot.sv - directed self-checking bench for control_fpgaram_boot
module tb_control_fpgaram_boot;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        micro_control = 1'b0;
  logic [21:0] m_addr = '0;
  logic [31:0] m_data = '0;
  logic [1:0]  m_lbub = 2'b11;
  logic        m_cs = 1'b1, m_we = 1'b1, m_oe = 1'b1, m_adv = 1'b1;
  logic        boot_start = 1'b0;
  logic [21:0] boot_len = '0;
  logic        fifo_empty = 1'b1;
  logic [31:0] fifo_data = '0;
  logic        stall = 1'b0;
  logic        rd_s = 1'b0;
  logic [31:0] fq[$];

  logic        rd, wait_o, done, ovf, cs, we, oe, adv;
  logic [21:0] address;
  logic [31:0] data;
  logic [1:0]  lbub;
  logic        h_rd, h_wait, h_done, h_ovf, h_cs, h_we, h_oe, h_adv;
  logic [21:0] h_address;
  logic [31:0] h_data;
  logic [1:0]  h_lbub;

  int tests_run = 0;
  int tests_failed = 0;

  int          mon_done_cyc, mon_hi_done_cyc, mon_wait_fall, mon_pops, mon_rd_bad;
  int          mon_we_low, mon_stall_strobe, mon_cs_low;
  logic        mon_wait_c1, mon_wait_seen;
  logic [21:0] wr_addr[$], hi_wr_addr[$];
  logic [31:0] wr_data[$];
  logic [21:0] snap_addr;
  logic [31:0] snap_data;
  logic [5:0]  snap_strb;

  always #5 clk = ~clk;

  control_fpgaram_boot #(.WAIT_CYCLES(2), .BASE_ADDR(22'h000000)) dut (
    .control_mem_clk_i(clk), .control_mem_rst_i(rst_n), .micro_control_i(micro_control),
    .micro_sram_address_i(m_addr), .micro_sram_datain_i(m_data), .micro_sram_lb_ub_i(m_lbub),
    .micro_sram_cs_i(m_cs), .micro_sram_we_i(m_we), .micro_sram_oe_i(m_oe), .micro_sram_adv_i(m_adv),
    .boot_start_i(boot_start), .boot_len_i(boot_len), .fifo_empty_i(fifo_empty),
    .fifo_datain_i(fifo_data), .read_fifo_o(rd), .sram_address_o(address), .sram_datain_o(data),
    .sram_lb_ub_o(lbub), .sram_cs_o(cs), .sram_we_o(we), .sram_oe_o(oe), .sram_adv_o(adv),
    .sram_wait_o(wait_o), .boot_done_o(done), .boot_ovf_o(ovf));

  control_fpgaram_boot #(.WAIT_CYCLES(2), .BASE_ADDR(22'h3FFFFE)) dut_hi (
    .control_mem_clk_i(clk), .control_mem_rst_i(rst_n), .micro_control_i(micro_control),
    .micro_sram_address_i(m_addr), .micro_sram_datain_i(m_data), .micro_sram_lb_ub_i(m_lbub),
    .micro_sram_cs_i(m_cs), .micro_sram_we_i(m_we), .micro_sram_oe_i(m_oe), .micro_sram_adv_i(m_adv),
    .boot_start_i(boot_start), .boot_len_i(boot_len), .fifo_empty_i(fifo_empty),
    .fifo_datain_i(fifo_data), .read_fifo_o(h_rd), .sram_address_o(h_address), .sram_datain_o(h_data),
    .sram_lb_ub_o(h_lbub), .sram_cs_o(h_cs), .sram_we_o(h_we), .sram_oe_o(h_oe), .sram_adv_o(h_adv),
    .sram_wait_o(h_wait), .boot_done_o(h_done), .boot_ovf_o(h_ovf));

  // Loader FIFO model: a pop seen during a cycle delivers data just after the next edge.
  always @(negedge clk) rd_s = rd;
  always @(posedge clk) begin
    #2;
    if (rd_s && fq.size() > 0) fifo_data = fq.pop_front();
    rd_s = 1'b0;
    fifo_empty = stall || (fq.size() == 0);
  end

  task automatic pulse_start(input logic [21:0] len);
    @(posedge clk); #1;
    boot_start = 1'b1;
    boot_len   = len;
    @(posedge clk); #1;
    boot_start = 1'b0;
  endtask

  task automatic monitor(input int budget, input int stall_from, input int stall_to,
                         input int micro_at, input int restart_at);
    logic prev_we, prev_hi_we, prev_rd;
    prev_we = 1'b1; prev_hi_we = 1'b1; prev_rd = 1'b0;
    mon_done_cyc = 0; mon_hi_done_cyc = 0; mon_wait_fall = 0; mon_pops = 0; mon_rd_bad = 0;
    mon_we_low = 0; mon_stall_strobe = 0; mon_cs_low = 0; mon_wait_c1 = 1'b0; mon_wait_seen = 1'b0;
    wr_addr.delete(); wr_data.delete(); hi_wr_addr.delete();
    for (int c = 1; c <= budget; c++) begin
      @(negedge clk);
      if (c == 1) mon_wait_c1 = wait_o;
      if (wait_o) mon_wait_seen = 1'b1;
      if (rd) begin
        mon_pops++;
        if (prev_rd || fifo_empty) mon_rd_bad++;
      end
      prev_rd = rd;
      if (!we) mon_we_low++;
      if (!cs) mon_cs_low++;
      if (!we && prev_we) begin
        wr_addr.push_back(address);
        wr_data.push_back(data);
      end
      prev_we = we;
      if (!h_we && prev_hi_we) hi_wr_addr.push_back(h_address);
      prev_hi_we = h_we;
      if (c >= stall_from && c <= stall_to && (!cs || !we)) mon_stall_strobe++;
      if (mon_wait_fall == 0 && c > 1 && !wait_o) begin
        mon_wait_fall = c;
        snap_addr = address;
        snap_data = data;
        snap_strb = {cs, we, oe, adv, lbub};
      end
      if (done && mon_done_cyc == 0) mon_done_cyc = c;
      if (h_done && mon_hi_done_cyc == 0) mon_hi_done_cyc = c;
      stall = (c + 1 >= stall_from) && (c + 1 <= stall_to);
      if (c + 1 == micro_at) begin
        micro_control = 1'b1;
        m_addr = 22'h0ABCDE; m_data = 32'hCAFEF00D; m_lbub = 2'b01;
        m_cs = 1'b0; m_we = 1'b1; m_oe = 1'b0; m_adv = 1'b0;
      end
      boot_start = (c + 1 == restart_at);
      if (c + 1 == restart_at) boot_len = 22'd5;
      if (mon_done_cyc != 0 && mon_hi_done_cyc != 0) break;
    end
    stall = 1'b0;
    boot_start = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    tests_run++;
    if ({cs, we, oe, adv, lbub, rd, wait_o, done, ovf} !== 10'b1111_11_0000) begin
      tests_failed++;
      $display("FAIL reset_ctrl: got %b expected %b", {cs, we, oe, adv, lbub, rd, wait_o, done, ovf}, 10'b1111110000);
    end
    tests_run++;
    if (address !== 22'h0 || data !== 32'h0) begin
      tests_failed++;
      $display("FAIL reset_addr_data: got %h/%h expected 0/0", address, data);
    end
  endtask

  task automatic test_micro;
    @(posedge clk); #1;
    micro_control = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    m_addr = 22'h15A5A5; m_data = 32'hDEADBEEF; m_cs = 1'b0; m_we = 1'b0; m_oe = 1'b1;
    m_adv = 1'b0; m_lbub = 2'b00;
    @(negedge clk);
    tests_run++;
    if (address !== 22'h0 || cs !== 1'b1) begin
      tests_failed++;
      $display("FAIL micro_not_early: got addr %h cs %b expected 0 and 1", address, cs);
    end
    @(negedge clk);
    tests_run++;
    if (address !== 22'h15A5A5 || data !== 32'hDEADBEEF) begin
      tests_failed++;
      $display("FAIL micro_addr_data: got %h/%h expected 15a5a5/deadbeef", address, data);
    end
    tests_run++;
    if ({cs, we, oe, adv, lbub} !== 6'b0010_00) begin
      tests_failed++;
      $display("FAIL micro_strobes: got %b expected 001000", {cs, we, oe, adv, lbub});
    end
    @(posedge clk); #1;
    micro_control = 1'b0; m_cs = 1'b1; m_we = 1'b1; m_oe = 1'b1; m_adv = 1'b1; m_lbub = 2'b11;
    repeat (2) @(posedge clk);
  endtask

  task automatic test_boot_basic;
    logic [31:0] exp_d[3];
    exp_d[0] = 32'h11111111; exp_d[1] = 32'h22222222; exp_d[2] = 32'h33333333;
    for (int i = 0; i < 3; i++) fq.push_back(exp_d[i]);
    pulse_start(22'd3);
    monitor(60, 0, 0, 0, 0);
    tests_run++;
    if (mon_done_cyc != 19 || mon_wait_fall != 19) begin
      tests_failed++;
      $display("FAIL basic_done_cycle: got done %0d wait_fall %0d expected 19/19", mon_done_cyc, mon_wait_fall);
    end
    tests_run++;
    if (mon_wait_c1 !== 1'b1 || wait_o !== 1'b0 || done !== 1'b1) begin
      tests_failed++;
      $display("FAIL basic_wait: got c1 %b end %b done %b expected 1/0/1", mon_wait_c1, wait_o, done);
    end
    tests_run++;
    if (mon_pops != 3 || mon_rd_bad != 0 || mon_we_low != 6) begin
      tests_failed++;
      $display("FAIL basic_pops: got pops %0d bad %0d we_low %0d expected 3/0/6", mon_pops, mon_rd_bad, mon_we_low);
    end
    tests_run++;
    if (wr_addr.size() != 3) begin
      tests_failed++;
      $display("FAIL basic_write_count: got %0d expected 3", wr_addr.size());
    end
    for (int i = 0; i < 3 && i < wr_addr.size(); i++) begin
      tests_run++;
      if (wr_addr[i] !== 22'(i) || wr_data[i] !== exp_d[i]) begin
        tests_failed++;
        $display("FAIL basic_write%0d: got %h/%h expected %h/%h", i, wr_addr[i], wr_data[i], 22'(i), exp_d[i]);
      end
    end
  endtask

  task automatic test_stall;
    fq.push_back(32'hA0000001); fq.push_back(32'hA0000002); fq.push_back(32'hA0000003);
    pulse_start(22'd3);
    monitor(60, 7, 11, 0, 0);
    tests_run++;
    if (mon_done_cyc != 24 || mon_pops != 3) begin
      tests_failed++;
      $display("FAIL stall_timing: got done %0d pops %0d expected 24/3", mon_done_cyc, mon_pops);
    end
    tests_run++;
    if (mon_stall_strobe != 0 || mon_rd_bad != 0) begin
      tests_failed++;
      $display("FAIL stall_quiet: got strobes %0d bad pops %0d expected 0/0", mon_stall_strobe, mon_rd_bad);
    end
    tests_run++;
    if (wr_data.size() != 3 || wr_data[0] !== 32'hA0000001 || wr_data[1] !== 32'hA0000002 ||
        wr_data[2] !== 32'hA0000003) begin
      tests_failed++;
      $display("FAIL stall_order: got %0d writes first %h expected 3 in order a0000001..3", wr_data.size(), wr_data[0]);
    end
  endtask

  task automatic test_overflow;
    for (int i = 0; i < 4; i++) fq.push_back(32'hB0000000 + i);
    pulse_start(22'd4);
    monitor(80, 0, 0, 0, 0);
    tests_run++;
    if (hi_wr_addr.size() != 2 || hi_wr_addr[0] !== 22'h3FFFFE || hi_wr_addr[1] !== 22'h3FFFFF) begin
      tests_failed++;
      $display("FAIL ovf_addrs: got %0d writes %h %h expected 2 at 3ffffe 3fffff", hi_wr_addr.size(), hi_wr_addr[0], hi_wr_addr[1]);
    end
    tests_run++;
    if (mon_hi_done_cyc != 13 || h_ovf !== 1'b1 || h_done !== 1'b1) begin
      tests_failed++;
      $display("FAIL ovf_flags: got done_cyc %0d ovf %b done %b expected 13/1/1", mon_hi_done_cyc, h_ovf, h_done);
    end
    tests_run++;
    if (mon_done_cyc != 25 || ovf !== 1'b0 || wr_addr.size() != 4) begin
      tests_failed++;
      $display("FAIL ovf_low_base: got done %0d ovf %b writes %0d expected 25/0/4", mon_done_cyc, ovf, wr_addr.size());
    end
  endtask

  task automatic test_back_to_back;
    fq.push_back(32'hC0000001); fq.push_back(32'hC0000002);
    pulse_start(22'd2);
    monitor(60, 0, 0, 0, 3);
    tests_run++;
    if (mon_done_cyc != 13 || wr_addr.size() != 2 || mon_pops != 2) begin
      tests_failed++;
      $display("FAIL busy_start: got done %0d writes %0d pops %0d expected 13/2/2", mon_done_cyc, wr_addr.size(), mon_pops);
    end
    tests_run++;
    if (mon_hi_done_cyc != 13 || h_ovf !== 1'b0) begin
      tests_failed++;
      $display("FAIL last_word_at_top: got done %0d ovf %b expected 13/0", mon_hi_done_cyc, h_ovf);
    end
  endtask

  task automatic test_handover;
    for (int i = 0; i < 4; i++) fq.push_back(32'hD0000000 + i);
    pulse_start(22'd4);
    monitor(12, 0, 0, 4, 0);
    tests_run++;
    if (wr_addr.size() != 1 || wr_data[0] !== 32'hD0000000 || mon_pops != 1) begin
      tests_failed++;
      $display("FAIL handover_word: got writes %0d data %h pops %0d expected 1/d0000000/1", wr_addr.size(), wr_data[0], mon_pops);
    end
    tests_run++;
    if (mon_done_cyc != 0 || mon_wait_fall != 7) begin
      tests_failed++;
      $display("FAIL handover_flags: got done_cyc %0d wait_fall %0d expected 0/7", mon_done_cyc, mon_wait_fall);
    end
    tests_run++;
    if (snap_addr !== 22'h0ABCDE || snap_data !== 32'hCAFEF00D || snap_strb !== 6'b0100_01) begin
      tests_failed++;
      $display("FAIL handover_bus: got %h/%h/%b expected 0abcde/cafef00d/010001", snap_addr, snap_data, snap_strb);
    end
    @(posedge clk); #1;
    micro_control = 1'b0; m_cs = 1'b1; m_we = 1'b1; m_oe = 1'b1; m_adv = 1'b1; m_lbub = 2'b11;
    fq.delete();
    repeat (2) @(posedge clk);
  endtask

  task automatic test_len_zero;
    pulse_start(22'd0);
    monitor(3, 0, 0, 0, 0);
    tests_run++;
    if (mon_done_cyc != 1 || mon_wait_seen !== 1'b0 || mon_cs_low != 0) begin
      tests_failed++;
      $display("FAIL len_zero: got done %0d wait %b cs_low %0d expected 1/0/0", mon_done_cyc, mon_wait_seen, mon_cs_low);
    end
  endtask

  task automatic test_reset_mid_write;
    fq.push_back(32'hE0000001); fq.push_back(32'hE0000002); fq.push_back(32'hE0000003);
    pulse_start(22'd3);
    monitor(4, 0, 0, 0, 0);
    tests_run++;
    if (we !== 1'b0 || cs !== 1'b0) begin
      tests_failed++;
      $display("FAIL midrst_in_write: got cs %b we %b expected 0/0", cs, we);
    end
    #2 rst_n = 1'b0;
    #1;
    tests_run++;
    if ({cs, we, oe, adv, lbub, rd, wait_o, done, ovf} !== 10'b1111_11_0000) begin
      tests_failed++;
      $display("FAIL midrst_ctrl: got %b expected 1111110000", {cs, we, oe, adv, lbub, rd, wait_o, done, ovf});
    end
    tests_run++;
    if (address !== 22'h0) begin
      tests_failed++;
      $display("FAIL midrst_addr: got %h expected 0", address);
    end
    fq.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
  endtask

  initial begin
    test_reset();
    test_micro();
    test_boot_basic();
    test_stall();
    test_overflow();
    test_back_to_back();
    test_handover();
    test_len_zero();
    test_reset_mid_write();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/control_fpgaram_boot.md
# control_fpgaram_boot

Parametrised SRAM/PSRAM front-end controller for the bootstrap FPGA design, successor to the fixed 22-bit/32-bit control block. It owns the external memory control pins and switches them between two masters. The first is a registered pass-through of the microcontroller's SRAM bus. The second is an internal boot engine that drains the loader FIFO into memory as timed write cycles with auto-incrementing address, a programmable word count and completion/overflow reporting.

## Interface
Parameters:
- ADDR_W, 22, memory word-address width
- DATA_W, 32, data width; must be a multiple of 16
- BE_W, DATA_W/16, lane-enable (lb_ub) width, active-low
- WAIT_CYCLES, 2, we-low cycles per write; legal range 1..15
- BASE_ADDR, 0, first address written by the boot engine

Ports:
- control_mem_clk_i  in  1  single clock, all logic rising-edge
- control_mem_rst_i  in  1  reset, asynchronous assert, active-low
- micro_control_i  in  1  1 = micro owns the bus, 0 = boot engine owns it
- micro_sram_address_i / _datain_i / _lb_ub_i  in  ADDR_W / DATA_W / BE_W  micro bus
- micro_sram_cs_i / _we_i / _oe_i / _adv_i  in  1 each  micro strobes, active-low
- boot_start_i  in  1  one-cycle pulse, starts a load
- boot_len_i  in  ADDR_W  number of words to load, sampled on boot_start_i
- fifo_empty_i  in  1  loader FIFO empty
- fifo_datain_i  in  DATA_W  FIFO read data, valid the cycle after read_fifo_o
- read_fifo_o  out  1  one-cycle FIFO pop
- sram_address_o / sram_datain_o / sram_lb_ub_o  out  ADDR_W / DATA_W / BE_W
- sram_cs_o / sram_we_o / sram_oe_o / sram_adv_o  out  1 each, active-low
- sram_wait_o  out  1  engine busy; micro must not drive cycles while high
- boot_done_o  out  1  level, set at load end, cleared by boot_start_i
- boot_ovf_o  out  1  level, load stopped at address wrap

## Operation
- Reset values:
  - address, data and boot counters: 0
  - cs, we, oe, adv: 1
  - lb_ub: all 1
  - read_fifo_o, sram_wait_o, boot_done_o, boot_ovf_o: 0
  - FSM: IDLE
- Owner mux:
  - Micro mode: all sram_* outputs are the micro inputs registered by one cycle.
  - Boot mode, engine in IDLE: strobes are held inactive.
- Boot FSM: IDLE, FETCH, LATCH, SETUP, WRITE, HOLD.
  - IDLE -> FETCH when boot_start_i=1, micro_control_i=0 and boot_len_i!=0. Loads addr=BASE_ADDR and remaining=boot_len_i, clears done/ovf, sets sram_wait_o.
  - boot_start_i with boot_len_i=0: boot_done_o=1 next cycle, no memory cycle.
  - FETCH: if fifo_empty_i=0, pulse read_fifo_o and go to LATCH; otherwise stay in FETCH (stall, no timeout).
  - LATCH: capture fifo_datain_i into sram_datain_o.
  - SETUP: cs=0, adv=0, oe=1, lb_ub=0, address driven.
  - WRITE: we=0 and adv=1 for WAIT_CYCLES cycles.
  - HOLD: we=1 and cs=1 for one cycle; decrement remaining and increment addr.
  - After HOLD:
    - remaining=0: go to IDLE with boot_done_o=1 and sram_wait_o=0.
    - addr was all-ones: go to IDLE with boot_done_o=1 and boot_ovf_o=1 (no wrap write).
    - otherwise: go to FETCH.
- Handover:
  - micro_control_i rising mid-load: the current word completes through HOLD, then the load aborts. Result: boot_done_o=0, sram_wait_o=0, micro takes the bus next cycle.
  - boot_start_i while busy: ignored.
- Reset mid-cycle: outputs return to reset values immediately (async). The partial write is abandoned.

## Timing
- Pass-through latency: 1 cycle.
- Boot word cost: WAIT_CYCLES+4 cycles when the FIFO is non-empty (FETCH, LATCH, SETUP, WRITE×N, HOLD).
- read_fifo_o is never high two consecutive cycles. It is only asserted with fifo_empty_i=0 sampled in the same cycle.
- sram_wait_o rises the cycle after the accepted boot_start_i and falls the same cycle boot_done_o rises.
- Address and data are stable from SETUP through HOLD.

## Structure
- Shared package fpgaram_pkg: FSM state enum; WAIT_CYCLES counter width (4 bits); strobe inactive constants.
- One sub-module, fpgaram_write_seq: the SETUP/WRITE/HOLD strobe sequencer with start/done handshake. The top keeps the mux, FIFO fetch and counters.

## Test plan
- Reset mid-WRITE (WAIT_CYCLES=2) -> cs/we/oe/adv=1, lb_ub=2'b11, read_fifo_o=0 within the same cycle reset is low.
- Micro mode, address 0x15A5A5, data 0xDEADBEEF, cs=0, we=0 -> identical values on sram_* exactly 1 cycle later.
- Boot, len=3, FIFO holds 0x11111111/0x22222222/0x33333333 -> writes to BASE_ADDR..+2, 6 cycles/word. boot_done_o=1 at cycle 19 after start; 3 read_fifo_o pulses.
- FIFO empty 5 cycles during word 2 -> FETCH stalls exactly 5 extra cycles; no strobes during the stall; data order preserved.
- BASE_ADDR=0x3FFFFE, len=4 -> writes 0x3FFFFE and 0x3FFFFF only, then boot_done_o=1 and boot_ovf_o=1.
- micro_control_i raised during WRITE of word 1 of 4 -> word 1 completes, boot_done_o stays 0, sram_wait_o drops after HOLD, micro values appear on the bus next cycle.
